// File: rtl/cla_clk.sv
// cla_clk: registered 32-bit carry-lookahead adder with two cycles of latency.
//
// Ports
//   clock    in   1   rising-edge clock for every register
//   reset_n  in   1   synchronous active-low reset, zeroes all registers
//   a        in  32   operand A, captured on every edge
//   b        in  32   operand B, captured on every edge
//   ci       in   1   carry-in, captured on every edge
//   s_cla    out 32   registered sum, (a + b + ci) mod 2^32
//   co_cla   out  1   registered carry-out, bit 32 of a + b + ci
//
// The datapath has no enables or stalls. Operands captured at edge N
// appear on s_cla/co_cla after edge N+1.
module cla_clk (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s_cla,
  output logic        co_cla
);

  logic [31:0] a_q, b_q;
  logic        ci_q;
  logic [31:0] s_q, s_d;
  logic        co_q, co_d;

  logic [31:0] g, p;
  logic [3:0]  gb, pb;
  logic [4:0]  cb;
  logic        blk_ci;

  // Eight 4-bit lookahead blocks. Each block computes all four of its
  // internal carries directly from the block carry-in. Block carry-outs
  // are chained from bits 3:0 up to bits 31:28.
  always_comb begin
    g      = a_q & b_q;
    p      = a_q ^ b_q;
    s_d    = '0;
    gb     = '0;
    pb     = '0;
    cb     = '0;
    blk_ci = ci_q;
    for (int k = 0; k < 8; k++) begin
      gb    = g[4*k +: 4];
      pb    = p[4*k +: 4];
      cb[0] = blk_ci;
      cb[1] = gb[0] | (pb[0] & cb[0]);
      cb[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cb[0]);
      cb[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
            | (pb[2] & pb[1] & pb[0] & cb[0]);
      cb[4] = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
            | (pb[3] & pb[2] & pb[1] & gb[0])
            | (pb[3] & pb[2] & pb[1] & pb[0] & cb[0]);
      s_d[4*k +: 4] = pb ^ cb[3:0];
      blk_ci        = cb[4];
    end
    co_d = blk_ci;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      ci_q <= 1'b0;
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      a_q  <= a;
      b_q  <= b;
      ci_q <= ci;
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign s_cla  = s_q;
  assign co_cla = co_q;

endmodule

// File: tb/tb_cla_clk.sv
module tb_cla_clk;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] a, b;
  logic        ci;
  logic [31:0] s_cla;
  logic        co_cla;

  int vectors = 0;
  int miscompares = 0;

  // Reference: a result pending in the capture stage and the result on the outputs.
  logic [32:0] ref_pend = '0;
  logic [32:0] ref_out  = '0;

  cla_clk dut (
    .clock   (clock),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .s_cla   (s_cla),
    .co_cla  (co_cla)
  );

  always #5 clock = ~clock;

  // One rising edge; updates the reference from the inputs seen at that edge,
  // then moves to a point 1 ns after the edge for driving and sampling.
  task automatic tick();
    @(posedge clock);
    if (!reset_n) begin
      ref_out  = '0;
      ref_pend = '0;
    end else begin
      ref_out  = ref_pend;
      ref_pend = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a = $urandom; b = $urandom; ci = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({co_cla, s_cla} !== 33'd0) begin
        miscompares++;
        $display("FAIL reset_state got %h required %h", {co_cla, s_cla}, 33'd0);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [7] = '{32'h00000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'h135FA562,
                            32'h135FA562, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] tb [7] = '{32'h00000000, 32'h00000000, 32'hFFFF0000, 32'h35614642,
                            32'h35614642, 32'h00000000, 32'hFFFFFFFF};
    logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [32:0] te [7] = '{33'h0_00000000, 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 33'h0_48C0EBA4,
                            33'h0_48C0EBA5, 33'h1_00000000, 33'h1_FFFFFFFF};
    logic [32:0] obs [9];
    reset_n = 1'b1;
    // Operands change every cycle: each result must land exactly two edges later.
    for (int i = 0; i < 9; i++) begin
      if (i < 7) begin a = ta[i]; b = tb[i]; ci = tc[i]; end
      else begin a = '0; b = '0; ci = 1'b0; end
      tick();
      obs[i] = {co_cla, s_cla};
      vectors++;
      if (obs[i] !== ref_out) begin
        miscompares++;
        $display("FAIL directed_model step %0d got %h required %h", i, obs[i], ref_out);
      end
    end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (obs[i+1] !== te[i]) begin
        miscompares++;
        $display("FAIL directed_const vec %0d got %h required %h", i, obs[i+1], te[i]);
      end
    end
  endtask

  task automatic test_no_comb_path();
    logic [32:0] held;
    reset_n = 1'b1;
    a = 32'h12345678; b = 32'h9ABCDEF0; ci = 1'b0;
    tick(); tick();
    held = {co_cla, s_cla};
    a = 32'hFFFFFFFF; b = 32'h00000001; ci = 1'b1;
    #2;
    vectors++;
    if ({co_cla, s_cla} !== held) begin
      miscompares++;
      $display("FAIL no_comb_path got %h required %h", {co_cla, s_cla}, held);
    end
    vectors++;
    if (held !== 33'h0_ACF13568) begin
      miscompares++;
      $display("FAIL hold_value got %h required %h", held, 33'h0_ACF13568);
    end
  endtask

  task automatic test_mid_reset();
    reset_n = 1'b1;
    a = 32'hFFFFFFFF; b = 32'h00000001; ci = 1'b0;
    tick(); tick();
    vectors++;
    if ({co_cla, s_cla} !== 33'h1_00000000) begin
      miscompares++;
      $display("FAIL pre_reset got %h required %h", {co_cla, s_cla}, 33'h1_00000000);
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if ({co_cla, s_cla} !== 33'd0) begin
      miscompares++;
      $display("FAIL mid_reset got %h required %h", {co_cla, s_cla}, 33'd0);
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if ({co_cla, s_cla} !== 33'd0) begin
      miscompares++;
      $display("FAIL release_edge got %h required %h", {co_cla, s_cla}, 33'd0);
    end
    tick();
    vectors++;
    if ({co_cla, s_cla} !== 33'h1_00000000) begin
      miscompares++;
      $display("FAIL release_result got %h required %h", {co_cla, s_cla}, 33'h1_00000000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = ~a; end
        1: begin a = 32'hFFFFFFFF; b = $urandom_range(0, 3); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      ci = $urandom_range(0, 1);
      tick();
      vectors++;
      if ({co_cla, s_cla} !== ref_out) begin
        miscompares++;
        $display("FAIL random step %0d got %h required %h", i, {co_cla, s_cla}, ref_out);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a = '0; b = '0; ci = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_no_comb_path();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
